// File: rtl/pipelined_mux_nx1.sv
// Registered N-to-1 operand-select mux with valid tracking, stall/flush control,
// sticky illegal-select flag and per-input saturating selection counters.
module pipelined_mux_nx1 #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 5,
  parameter int SEL_W  = 3,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NUM_IN*WIDTH-1:0] IN,
  input  logic [SEL_W-1:0]        SELECT,
  input  logic                    IN_VALID,
  input  logic                    STALL,
  input  logic                    FLUSH,
  input  logic                    CNT_CLEAR,
  input  logic [SEL_W-1:0]        CNT_IDX,
  output logic [WIDTH-1:0]        OUT,
  output logic                    OUT_VALID,
  output logic                    SEL_ERROR,
  output logic [CNT_W-1:0]        CNT_OUT
);

  // Handshake: a beat is taken whenever IN_VALID is high and neither STALL nor
  // FLUSH is; there is no ready, so the producer must treat STALL as backpressure.
  logic             accept;
  logic             sel_legal;
  logic [WIDTH-1:0] sel_data;
  logic [WIDTH-1:0] in_arr [NUM_IN];
  logic [WIDTH-1:0] stg_d  [STAGES];
  logic             stg_v  [STAGES];
  logic [CNT_W-1:0] cnt    [NUM_IN];

  for (genvar g = 0; g < NUM_IN; g++) begin : g_unpack
    assign in_arr[g] = IN[g*WIDTH +: WIDTH];
  end

  assign accept    = IN_VALID & ~STALL & ~FLUSH;
  assign sel_legal = (32'(SELECT) < NUM_IN);

  // Out-of-range selects fall back to input 0, as the legacy mux did.
  always_comb begin
    sel_data = in_arr[0];
    for (int k = 1; k < NUM_IN; k++) begin
      if (SELECT == SEL_W'(k)) sel_data = in_arr[k];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      for (int i = 0; i < STAGES; i++) begin
        stg_d[i] <= '0;
        stg_v[i] <= 1'b0;
      end
    end else if (!STALL) begin
      stg_d[0] <= IN_VALID ? sel_data : '0;
      stg_v[0] <= IN_VALID;
      for (int i = 1; i < STAGES; i++) begin
        stg_d[i] <= stg_d[i-1];
        stg_v[i] <= stg_v[i-1];
      end
    end
  end

  assign OUT       = stg_d[STAGES-1];
  assign OUT_VALID = stg_v[STAGES-1];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      SEL_ERROR <= 1'b0;
    end else if (accept && !sel_legal) begin
      SEL_ERROR <= 1'b1;
    end
  end

  // Clear beats a same-cycle increment; counters stop at all-ones.
  always_ff @(posedge CLK) begin
    if (RESET || CNT_CLEAR) begin
      for (int k = 0; k < NUM_IN; k++) cnt[k] <= '0;
    end else if (accept && sel_legal) begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (SELECT == SEL_W'(k) && cnt[k] != {CNT_W{1'b1}}) cnt[k] <= cnt[k] + 1'b1;
      end
    end
  end

  always_comb begin
    CNT_OUT = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (CNT_IDX == SEL_W'(k)) CNT_OUT = cnt[k];
    end
  end

endmodule

// File: tb/tb_pipelined_mux_nx1.sv
// Bench for pipelined_mux_nx1: three instances (1 stage, 2 stages, 4-bit counters)
// share one stimulus stream and are checked against a beat-history reference model.
module tb_pipelined_mux_nx1;
  localparam int W  = 32;
  localparam int N  = 5;
  localparam int SW = 3;

  // clock / reset
  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic            reset, in_valid, stall, flush, cnt_clear;
  logic [N*W-1:0]  in_bus;
  logic [SW-1:0]   sel, cnt_idx;

  logic [W-1:0] out_a, out_b, out_c;
  logic         vld_a, vld_b, vld_c;
  logic         err_a, err_b, err_c;
  logic [15:0]  cnt_a, cnt_b;
  logic [3:0]   cnt_c;

  pipelined_mux_nx1 #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .STAGES(1), .CNT_W(16)) dut_a (
    .CLK(CLK), .RESET(reset), .IN(in_bus), .SELECT(sel), .IN_VALID(in_valid),
    .STALL(stall), .FLUSH(flush), .CNT_CLEAR(cnt_clear), .CNT_IDX(cnt_idx),
    .OUT(out_a), .OUT_VALID(vld_a), .SEL_ERROR(err_a), .CNT_OUT(cnt_a));

  pipelined_mux_nx1 #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .STAGES(2), .CNT_W(16)) dut_b (
    .CLK(CLK), .RESET(reset), .IN(in_bus), .SELECT(sel), .IN_VALID(in_valid),
    .STALL(stall), .FLUSH(flush), .CNT_CLEAR(cnt_clear), .CNT_IDX(cnt_idx),
    .OUT(out_b), .OUT_VALID(vld_b), .SEL_ERROR(err_b), .CNT_OUT(cnt_b));

  pipelined_mux_nx1 #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW), .STAGES(1), .CNT_W(4)) dut_c (
    .CLK(CLK), .RESET(reset), .IN(in_bus), .SELECT(sel), .IN_VALID(in_valid),
    .STALL(stall), .FLUSH(flush), .CNT_CLEAR(cnt_clear), .CNT_IDX(cnt_idx),
    .OUT(out_c), .OUT_VALID(vld_c), .SEL_ERROR(err_c), .CNT_OUT(cnt_c));

  // reference model: history of beats entering the pipe, newest at the back
  logic [32:0] hist[$];
  int          cnt_m [3][N];
  int          cnt_max [3] = '{65535, 65535, 15};
  logic        err_m;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [W-1:0] word(input int k);
    return in_bus[k*W +: W];
  endfunction

  task automatic model_edge();
    int  s;
    bit  acc;
    s   = int'(sel);
    acc = in_valid && !stall && !flush;
    if (reset) begin
      hist.push_back(33'd0);
      hist.push_back(33'd0);
      err_m = 1'b0;
      for (int i = 0; i < 3; i++) for (int k = 0; k < N; k++) cnt_m[i][k] = 0;
    end else begin
      if (flush) begin
        hist.push_back(33'd0);
        hist.push_back(33'd0);
      end else if (!stall) begin
        hist.push_back(in_valid ? {1'b1, word(s < N ? s : 0)} : 33'd0);
      end
      if (acc && s >= N) err_m = 1'b1;
      for (int i = 0; i < 3; i++) begin
        if (cnt_clear) begin
          for (int k = 0; k < N; k++) cnt_m[i][k] = 0;
        end else if (acc && s < N && cnt_m[i][s] < cnt_max[i]) begin
          cnt_m[i][s] = cnt_m[i][s] + 1;
        end
      end
    end
    while (hist.size() > 4) void'(hist.pop_front());
  endtask

  // scoreboard comparison
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [32:0] exp_beat(input int stages);
    return hist[hist.size() - stages];
  endfunction

  function automatic int exp_cnt(input int i);
    return (int'(cnt_idx) < N) ? cnt_m[i][cnt_idx] : 0;
  endfunction

  task automatic check_all();
    logic [32:0] e1, e2;
    e1 = exp_beat(1);
    e2 = exp_beat(2);
    check("a_out", out_a, e1[31:0]);
    check("a_vld", 32'(vld_a), 32'(e1[32]));
    check("b_out", out_b, e2[31:0]);
    check("b_vld", 32'(vld_b), 32'(e2[32]));
    check("c_out", out_c, e1[31:0]);
    check("c_vld", 32'(vld_c), 32'(e1[32]));
    check("a_err", 32'(err_a), 32'(err_m));
    check("b_err", 32'(err_b), 32'(err_m));
    check("c_err", 32'(err_c), 32'(err_m));
    check("a_cnt", 32'(cnt_a), 32'(exp_cnt(0)));
    check("b_cnt", 32'(cnt_b), 32'(exp_cnt(1)));
    check("c_cnt", 32'(cnt_c), 32'(exp_cnt(2)));
  endtask

  // driver: inputs change at negedge, DUT samples at posedge, outputs checked at negedge
  task automatic step();
    @(posedge CLK);
    model_edge();
    @(negedge CLK);
    check_all();
  endtask

  task automatic set_beat(input bit v, input int s);
    in_valid = v;
    sel      = SW'(s);
  endtask

  initial begin
    hist.push_back(33'd0);
    hist.push_back(33'd0);
    err_m = 1'b0;
    for (int i = 0; i < 3; i++) for (int k = 0; k < N; k++) cnt_m[i][k] = 0;
    reset = 1'b1; in_valid = 1'b0; stall = 1'b0; flush = 1'b0; cnt_clear = 1'b0;
    sel = '0; cnt_idx = '0; in_bus = '0;
    step();
    step();
    check("rst_out", out_a, 32'd0);
    check("rst_vld", 32'(vld_b), 32'd0);
    reset = 1'b0;

    // single beat through the 1-stage instance
    in_bus[3*W +: W] = 32'hDEADBEEF;
    cnt_idx = 3'd3;
    set_beat(1, 3);
    step();
    check("p1_out", out_a, 32'hDEADBEEF);
    check("p1_cnt", 32'(cnt_a), 32'd1);

    // consecutive beats through the 2-stage instance
    for (int k = 0; k < N; k++) in_bus[k*W +: W] = 32'h1000 + 32'(k);
    set_beat(1, 0); step();
    set_beat(1, 1); step();
    check("p2_e2", out_b, 32'h1000);
    set_beat(1, 2); step();
    check("p2_e3", out_b, 32'h1001);
    set_beat(0, 0); step();
    check("p2_e4", out_b, 32'h1002);
    step();

    // stall with one beat in stage 1 of the 2-stage instance
    set_beat(1, 4); step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("p3_frozen", 32'(vld_b), 32'd0);
    stall = 1'b0; set_beat(0, 0); step();
    check("p3_emerge", out_b, 32'h1004);
    step();
    check("p3_nodup", 32'(vld_b), 32'd0);

    // flush together with stall while two beats are in flight
    cnt_idx = 3'd1;
    set_beat(1, 1); step();
    set_beat(1, 2); step();
    flush = 1'b1; stall = 1'b1; step();
    check("p4_out", out_b, 32'd0);
    check("p4_cnt", 32'(cnt_b), 32'd2);
    flush = 1'b0; stall = 1'b0; set_beat(0, 0); step();

    // illegal select: falls back to input 0, sticky through flush, cleared by reset
    set_beat(1, 7); step();
    check("p5_out", out_a, 32'h1000);
    check("p5_err", 32'(err_a), 32'd1);
    set_beat(0, 0); flush = 1'b1; step();
    flush = 1'b0; step();
    check("p5_sticky", 32'(err_c), 32'd1);
    reset = 1'b1; step();
    reset = 1'b0; step();
    check("p5_clr", 32'(err_b), 32'd0);

    // saturation of the 4-bit counters, then clear against an increment
    cnt_idx = 3'd2;
    set_beat(1, 2);
    for (int i = 0; i < 20; i++) step();
    check("p6_sat", 32'(cnt_c), 32'd15);
    check("p6_wide", 32'(cnt_a), 32'd20);
    cnt_clear = 1'b1; step();
    cnt_clear = 1'b0; set_beat(0, 0); step();
    check("p6_clr", 32'(cnt_c), 32'd0);
    cnt_idx = 3'd6; set_beat(1, 1); step();
    check("p6_idx6", 32'(cnt_a), 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++) in_bus[k*W +: W] = $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      sel       = SW'($urandom_range(0, 7));
      stall     = ($urandom_range(0, 4) == 0);
      flush     = ($urandom_range(0, 9) == 0);
      cnt_clear = ($urandom_range(0, 29) == 0);
      reset     = ($urandom_range(0, 59) == 0);
      cnt_idx   = SW'($urandom_range(0, 7));
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
